// File: rtl/vga_frame_scanout_if.sv
// Frame-buffer read port shared by the scanout engine and the frame RAM.
// The master issues addresses and strobes; the slave returns data one clock later.
interface vga_frame_scanout_if;
   logic [18:0] fb_read_addr;
   logic        fb_rd_en;
   logic [7:0]  fb_data;

   modport master (
      output fb_read_addr,
      output fb_rd_en,
      input  fb_data
   );

   modport slave (
      input  fb_read_addr,
      input  fb_rd_en,
      output fb_data
   );
endinterface

// File: rtl/vga_frame_scanout.sv
// VGA scanout of the zoomed frame buffer, centred in the active area.
// Counters -> address/strobe -> RAM data -> pins, a fixed 3-cycle pipeline.
module vga_frame_scanout #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter logic [7:0]  BORDER   = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           zoom_level,
   input  logic                 frame_ready,
   vga_frame_scanout_if.master  fb,
   output logic [7:0]           vga_pixel,
   output logic                 vga_hsync,
   output logic                 vga_vsync,
   output logic                 vga_de,
   output logic                 frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic          run;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [2:0]    zoom_q;
   logic          ready_q;
   logic [18:0]   addr_cnt;

   logic          origin;
   logic [2:0]    zoom_eff;
   logic          ready_eff;
   logic [1:0]    shift;
   logic [HW-1:0] x0;
   logic [HW-1:0] x1;
   logic [VW-1:0] y0;
   logic [VW-1:0] y1;
   logic          in_win;
   logic          de0;
   logic          hs0;
   logic          vs0;
   logic [18:0]   addr_cur;

   logic          de1, hs1, vs1, fs1;
   logic          win2, de2, hs2, vs2, fs2;

   // Window geometry; at the frame origin the live inputs are used so the
   // very first pixel already reflects the settings being latched.
   always_comb begin
      origin    = (h_cnt == '0) && (v_cnt == '0);
      zoom_eff  = origin ? zoom_level : zoom_q;
      ready_eff = origin ? frame_ready : ready_q;
      shift     = 2'd2;
      unique case (1'b1)
         (zoom_eff == 3'd4): shift = 2'd0;
         (zoom_eff == 3'd3): shift = 2'd1;
         default:            shift = 2'd2;
      endcase
      x0 = (H_ACT - (H_ACT >> shift)) >> 1;
      x1 = x0 + (H_ACT >> shift);
      y0 = (V_ACT - (V_ACT >> shift)) >> 1;
      y1 = y0 + (V_ACT >> shift);
      in_win = run && ready_eff &&
               (h_cnt >= x0) && (h_cnt < x1) &&
               (v_cnt >= y0) && (v_cnt < y1);
      de0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs0 = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs0 = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      addr_cur = origin ? '0 : addr_cnt;
   end

   // Raster counters, per-frame settings and the linear read address.
   // The first edge after reset only arms the engine, holding (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run      <= 1'b0;
         h_cnt    <= '0;
         v_cnt    <= '0;
         zoom_q   <= 3'd0;
         ready_q  <= 1'b0;
         addr_cnt <= '0;
      end else begin
         run <= 1'b1;
         if (run) begin
            if (origin) begin
               zoom_q  <= zoom_level;
               ready_q <= frame_ready;
            end
            addr_cnt <= in_win ? addr_cur + 19'd1 : addr_cur;
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

   // Stage 1: read request plus timing flags for the same pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb.fb_read_addr <= '0;
         fb.fb_rd_en     <= 1'b0;
         de1             <= 1'b0;
         hs1             <= 1'b1;
         vs1             <= 1'b1;
         fs1             <= 1'b0;
      end else begin
         fb.fb_rd_en <= in_win;
         if (in_win) fb.fb_read_addr <= addr_cur;
         de1 <= run && de0;
         hs1 <= !run || hs0;
         vs1 <= !run || vs0;
         fs1 <= run && origin;
      end
   end

   // Stage 2: flags wait while the RAM produces data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win2 <= 1'b0;
         de2  <= 1'b0;
         hs2  <= 1'b1;
         vs2  <= 1'b1;
         fs2  <= 1'b0;
      end else begin
         win2 <= fb.fb_rd_en;
         de2  <= de1;
         hs2  <= hs1;
         vs2  <= vs1;
         fs2  <= fs1;
      end
   end

   // Stage 3: pixel select and registered pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_pixel   <= 8'h00;
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         vga_de      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vga_pixel   <= win2 ? fb.fb_data : (de2 ? BORDER : 8'h00);
         vga_hsync   <= hs2;
         vga_vsync   <= vs2;
         vga_de      <= de2;
         frame_start <= fs2;
      end
   end

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Bench for vga_frame_scanout on a scaled-down raster (80x55 totals).
// Expected values come from a per-position arithmetic model of the display.
module tb_vga_frame_scanout;

   localparam int HA = 64;
   localparam int HF = 4;
   localparam int HS = 8;
   localparam int HB = 4;
   localparam int VA = 48;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam logic [7:0] BRD = 8'h3C;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] zoom_level = 3'd4;
   logic       frame_ready = 1'b1;
   logic [7:0] vga_pixel;
   logic       vga_hsync;
   logic       vga_vsync;
   logic       vga_de;
   logic       frame_start;

   vga_frame_scanout_if fb();

   vga_frame_scanout #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .BORDER(BRD)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .zoom_level(zoom_level),
      .frame_ready(frame_ready),
      .fb(fb),
      .vga_pixel(vga_pixel),
      .vga_hsync(vga_hsync),
      .vga_vsync(vga_vsync),
      .vga_de(vga_de),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Frame RAM: returns the low address byte one clock after the request.
   always @(posedge clk) fb.fb_data <= fb.fb_read_addr[7:0];

   int total = 0;
   int bad = 0;
   int e = 0;
   bit in_rst = 1'b1;
   int fz [0:15];
   bit fr [0:15];
   int rdcnt [0:15];
   int last_addr = 0;
   int fs_q [$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s e=%0d observed=%0h expected=%0h", tag, e, obs, exp);
      end
   endtask

   function automatic int area(input int z, input bit r);
      int s;
      s = (z == 4) ? 0 : ((z == 3) ? 1 : 2);
      return r ? (HA >> s) * (VA >> s) : 0;
   endfunction

   function automatic void model(input int idx, output bit de, output bit hs,
                                 output bit vs, output bit fs, output bit w,
                                 output int a);
      int f, r, h, v, s, ww, hh, x0, y0;
      f  = idx / FT;
      r  = idx % FT;
      h  = r % HT;
      v  = r / HT;
      s  = (fz[f] == 4) ? 0 : ((fz[f] == 3) ? 1 : 2);
      ww = HA >> s;
      hh = VA >> s;
      x0 = (HA - ww) / 2;
      y0 = (VA - hh) / 2;
      de = (h < HA) && (v < VA);
      hs = !((h >= HA + HF) && (h < HA + HF + HS));
      vs = !((v >= VA + VF) && (v < VA + VF + VS));
      fs = (h == 0) && (v == 0);
      w  = fr[f] && (h >= x0) && (h < x0 + ww) && (v >= y0) && (v < y0 + hh);
      a  = (v - y0) * ww + (h - x0);
   endfunction

   task automatic chk_pins(input logic [7:0] p, input bit de, input bit hs,
                           input bit vs, input bit fs);
      chk("pixel", vga_pixel, p);
      chk("de", vga_de, de);
      chk("hsync", vga_hsync, hs);
      chk("vsync", vga_vsync, vs);
      chk("frame_start", frame_start, fs);
   endtask

   task automatic chk_reset();
      chk("rst_rd_en", fb.fb_rd_en, 0);
      chk("rst_addr", fb.fb_read_addr, 0);
      chk_pins(8'h00, 0, 1, 1, 0);
   endtask

   task automatic check_cycle();
      bit de, hs, vs, fs, w;
      int a;
      if (in_rst) begin
         chk_reset();
         return;
      end
      if (e - 2 < 0) begin
         chk("rd_en", fb.fb_rd_en, 0);
         chk("rd_addr", fb.fb_read_addr, last_addr);
      end else begin
         model(e - 2, de, hs, vs, fs, w, a);
         if (w) last_addr = a;
         chk("rd_en", fb.fb_rd_en, w);
         chk("rd_addr", fb.fb_read_addr, last_addr);
         if (fb.fb_rd_en === 1'b1) rdcnt[(e - 2) / FT]++;
      end
      if (e - 4 < 0) begin
         chk_pins(8'h00, 0, 1, 1, 0);
      end else begin
         model(e - 4, de, hs, vs, fs, w, a);
         chk_pins(w ? a[7:0] : (de ? BRD : 8'h00), de, hs, vs, fs);
      end
      if (frame_start === 1'b1) fs_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!in_rst) begin
         e++;
         if (e >= 2 && (e - 2) % FT == 0) begin
            fz[(e - 2) / FT] = int'(zoom_level);
            fr[(e - 2) / FT] = frame_ready;
         end
      end
      @(negedge clk);
      check_cycle();
   endtask

   task automatic adv_to(input int target);
      while (e < target) tick();
   endtask

   task automatic setup(input int f, input int z, input bit r);
      adv_to((f - 1) * FT + 2 + FT / 2);
      zoom_level  = 3'($urandom_range(0, 7));
      frame_ready = 1'($urandom_range(0, 1));
      repeat (50) tick();
      zoom_level  = 3'(z);
      frame_ready = r;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) begin
         fz[i] = 0;
         fr[i] = 1'b0;
         rdcnt[i] = 0;
      end
      fs_q.delete();
      last_addr = 0;
      e = 0;
   endtask

   initial begin
      int z0, z1;
      clear_model();
      rst_n = 1'b0;
      in_rst = 1'b1;
      zoom_level = 3'd4;
      frame_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      in_rst = 1'b0;

      setup(1, 2, 1'b1);
      setup(2, 0, 1'b1);
      setup(3, 3, 1'b1);
      setup(4, 4, 1'b1);
      setup(5, 4, 1'b0);
      setup(6, 7, 1'b1);
      adv_to(6 * FT + 2 + 20 * HT + 30);
      chk("rd_before_rst", fb.fb_rd_en, 1);

      chk("reads_f0_z4", rdcnt[0], area(4, 1));
      chk("reads_f1_z2", rdcnt[1], area(2, 1));
      chk("reads_f2_z0", rdcnt[2], area(0, 1));
      chk("reads_f3_z3", rdcnt[3], area(3, 1));
      chk("reads_f4_z4", rdcnt[4], area(4, 1));
      chk("reads_f5_off", rdcnt[5], 0);
      chk("fs_first", fs_q.size() > 0 ? fs_q[0] : -1, 4);
      chk("fs_second", fs_q.size() > 1 ? fs_q[1] : -1, 4 + FT);

      #2 rst_n = 1'b0;
      #1 in_rst = 1'b1;
      chk_reset();
      repeat (3) tick();

      clear_model();
      z0 = int'($urandom_range(0, 7));
      z1 = int'($urandom_range(0, 7));
      zoom_level = 3'(z0);
      frame_ready = 1'b1;
      rst_n = 1'b1;
      in_rst = 1'b0;
      setup(1, z1, 1'b1);
      adv_to(2 * FT + 2 + 10);

      chk("reads_rst_f0", rdcnt[0], area(z0, 1));
      chk("reads_rst_f1", rdcnt[1], area(z1, 1));
      chk("fs_rst_first", fs_q.size() > 0 ? fs_q[0] : -1, 4);
      chk("fs_rst_second", fs_q.size() > 1 ? fs_q[1] : -1, 4 + FT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
